// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/subtract unit.
// Operands are loaded in parallel and processed LSB-first, one bit per
// clock, through a single full-adder slice and a carry/borrow flop.
// A START/BUSY/DONE handshake allows back-to-back operations. RESULT,
// CB_OUT and OVF hold the last completed operation.
// Optional feature: define SERIAL_ADDSUB_ZERO_FLAG_EN to add a registered
// ZERO output (RESULT == 0), reset value 1.
module serial_addsub #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             SUB,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             CB_IN,
   output logic [WIDTH-1:0] RESULT,
   output logic             CB_OUT,
   output logic             OVF,
   output logic             BUSY,
   output logic             DONE
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
   ,
   output logic             ZERO
`endif
);

   // Counter is wide enough to hold WIDTH without wrapping.
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-1:0]   r_sr;
   logic               sub_q;
   logic               carry;
   logic [CNT_W-1:0]   count;

   logic               b_bit;
   logic               sum_bit;
   logic               carry_nxt;
   logic               last_bit;
   logic               load;
   logic [WIDTH-1:0]   res_nxt;

   // Full-adder slice on the current LSBs; Y bit inverted for subtraction.
   always_comb begin
      b_bit     = b_sr[0] ^ sub_q;
      sum_bit   = a_sr[0] ^ b_bit ^ carry;
      carry_nxt = (a_sr[0] & b_bit) | (a_sr[0] & carry) | (b_bit & carry);
      res_nxt   = {sum_bit, r_sr[WIDTH-1:1]};
      last_bit  = (count == CNT_W'(WIDTH - 1));
      load      = START && ((state == IDLE) || (state == FIN));
   end

   // Control FSM, datapath shift registers and registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         r_sr   <= '0;
         sub_q  <= 1'b0;
         carry  <= 1'b0;
         count  <= '0;
         RESULT <= '0;
         CB_OUT <= 1'b0;
         OVF    <= 1'b0;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
         ZERO   <= 1'b1;
`endif
      end else begin
         DONE <= 1'b0;
         if (load) begin
            // Subtraction is X + ~Y + 1 - CB_IN, so the carry flop starts at ~CB_IN.
            a_sr  <= X;
            b_sr  <= Y;
            sub_q <= SUB;
            carry <= SUB ^ CB_IN;
            r_sr  <= '0;
            count <= '0;
            BUSY  <= 1'b1;
            state <= SHIFT;
         end else begin
            case (state)
               IDLE: begin
                  state <= IDLE;
               end
               SHIFT: begin
                  a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                  b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                  r_sr  <= res_nxt;
                  carry <= carry_nxt;
                  count <= count + CNT_W'(1);
                  if (last_bit) begin
                     // MSB slice: publish result, carry/borrow and overflow together.
                     RESULT <= res_nxt;
                     CB_OUT <= carry_nxt ^ sub_q;
                     OVF    <= carry ^ carry_nxt;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
                     ZERO   <= (res_nxt == '0);
`endif
                     BUSY   <= 1'b0;
                     DONE   <= 1'b1;
                     state  <= FIN;
                  end
               end
               FIN: begin
                  state <= IDLE;
               end
               default: begin
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub (WIDTH=4): directed vector table plus
// back-to-back, ignored-START and reset-abort sequences.
module tb_serial_addsub;

   localparam int unsigned W = 4;

   logic         CLK;
   logic         RST;
   logic         START;
   logic         SUB;
   logic [W-1:0] X;
   logic [W-1:0] Y;
   logic         CB_IN;
   logic [W-1:0] RESULT;
   logic         CB_OUT;
   logic         OVF;
   logic         BUSY;
   logic         DONE;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
   logic         ZERO;
`endif

   serial_addsub #(.WIDTH(W)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .START  (START),
      .SUB    (SUB),
      .X      (X),
      .Y      (Y),
      .CB_IN  (CB_IN),
      .RESULT (RESULT),
      .CB_OUT (CB_OUT),
      .OVF    (OVF),
      .BUSY   (BUSY),
      .DONE   (DONE)
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
      ,
      .ZERO   (ZERO)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         cb;
      logic         sub;
      logic [W-1:0] res;
      logic         cbo;
      logic         ovf;
   } vec_t;

   vec_t vecs [8];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present an operation at the falling edge; returns #1 after the load edge.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic cb, input logic sub);
      @(negedge CLK);
      START = 1'b1;
      X     = x;
      Y     = y;
      CB_IN = cb;
      SUB   = sub;
      @(posedge CLK);
      #1;
      START = 1'b0;
   endtask

   // From #1 after the load edge: BUSY for W-1 edges, DONE on the W-th.
   task automatic wait_done(input string name);
      for (int i = 1; i <= int'(W); i++) begin
         @(posedge CLK);
         #1;
         if (i < int'(W)) begin
            check({name, " busy"}, 32'(BUSY), 32'd1);
            check({name, " done early"}, 32'(DONE), 32'd0);
         end else begin
            check({name, " done"}, 32'(DONE), 32'd1);
            check({name, " busy fin"}, 32'(BUSY), 32'd0);
         end
      end
   endtask

   task automatic check_out(input string name, input logic [W-1:0] res,
                            input logic cbo, input logic ovf);
      check({name, " result"}, 32'(RESULT), 32'(res));
      check({name, " cb_out"}, 32'(CB_OUT), 32'(cbo));
      check({name, " ovf"}, 32'(OVF), 32'(ovf));
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
      check({name, " zero"}, 32'(ZERO), 32'(res == '0));
`endif
   endtask

   initial begin
      // x, y, cb_in, sub, result, cb_out, ovf
      vecs[0] = '{4'b0100, 4'b1000, 1'b0, 1'b0, 4'b1100, 1'b0, 1'b0};
      vecs[1] = '{4'b0011, 4'b0111, 1'b1, 1'b0, 4'b1011, 1'b0, 1'b1};
      vecs[2] = '{4'b1111, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0};
      vecs[3] = '{4'b0111, 4'b0001, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1};
      vecs[4] = '{4'b0000, 4'b0001, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0};
      vecs[5] = '{4'b1000, 4'b0001, 1'b0, 1'b1, 4'b0111, 1'b0, 1'b1};
      vecs[6] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0};
      vecs[7] = '{4'b0110, 4'b0110, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0};

      RST   = 1'b1;
      START = 1'b0;
      SUB   = 1'b0;
      X     = '0;
      Y     = '0;
      CB_IN = 1'b0;

      // Reset values are visible before the first clock edge.
      #3;
      check_out("reset", 4'b0000, 1'b0, 1'b0);
      check("reset busy", 32'(BUSY), 32'd0);
      check("reset done", 32'(DONE), 32'd0);
      @(negedge CLK);
      RST = 1'b0;

      // Table-driven vectors, each followed by a one-cycle DONE / hold check.
      for (int i = 0; i < 8; i++) begin
         issue(vecs[i].x, vecs[i].y, vecs[i].cb, vecs[i].sub);
         wait_done($sformatf("vec%0d", i));
         check_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].cbo, vecs[i].ovf);
         @(posedge CLK);
         #1;
         check($sformatf("vec%0d done pulse", i), 32'(DONE), 32'd0);
         check_out($sformatf("vec%0d hold", i), vecs[i].res, vecs[i].cbo, vecs[i].ovf);
      end

      // Subtract with overflow, then a new START issued in the FIN cycle.
      issue(4'b1100, 4'b0101, 1'b0, 1'b1);
      wait_done("b2b first");
      check_out("b2b first", 4'b0111, 1'b0, 1'b1);
      START = 1'b1;
      X     = 4'b0011;
      Y     = 4'b0111;
      CB_IN = 1'b1;
      SUB   = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      check("b2b reload busy", 32'(BUSY), 32'd1);
      check("b2b reload done", 32'(DONE), 32'd0);
      check_out("b2b hold during shift", 4'b0111, 1'b0, 1'b1);
      wait_done("b2b second");
      check_out("b2b second", 4'b1011, 1'b1, 1'b0);

      // START and operand changes while BUSY do not affect the running op.
      issue(4'b0110, 4'b0011, 1'b0, 1'b0);
      START = 1'b1;
      X     = 4'b1111;
      Y     = 4'b1111;
      CB_IN = 1'b1;
      SUB   = 1'b1;
      wait_done("ignore start");
      START = 1'b0;
      check_out("ignore start", 4'b1001, 1'b0, 1'b1);
      @(posedge CLK);
      #1;
      check("ignore start idle busy", 32'(BUSY), 32'd0);
      check("ignore start idle done", 32'(DONE), 32'd0);

      // Abort: reset after the second shift edge clears outputs immediately.
      issue(4'b1111, 4'b0001, 1'b0, 1'b0);
      START = 1'b1;
      X     = 4'b0101;
      Y     = 4'b0101;
      SUB   = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      check("abort busy", 32'(BUSY), 32'd1);
      @(posedge CLK);
      #2;
      RST = 1'b1;
      #1;
      check_out("abort reset", 4'b0000, 1'b0, 1'b0);
      check("abort reset busy", 32'(BUSY), 32'd0);
      check("abort reset done", 32'(DONE), 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(posedge CLK);
         #1;
         check("abort no done", 32'(DONE), 32'd0);
      end
      // START on the first edge after reset release is accepted.
      @(negedge CLK);
      RST   = 1'b0;
      START = 1'b1;
      X     = 4'b0001;
      Y     = 4'b0001;
      CB_IN = 1'b0;
      SUB   = 1'b0;
      @(posedge CLK);
      #1;
      START = 1'b0;
      check("post reset busy", 32'(BUSY), 32'd1);
      wait_done("post reset");
      check_out("post reset", 4'b0010, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
